// File: rtl/psmac_operand_packer.sv
// Operand packer for the precision-scalable MAC PE: packs (x, w) pairs into the
// PE's 32-bit digit layout with sign-control vectors and precision selects.
module psmac_operand_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cfg_prec,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_w,
  input  logic        in_xs,
  input  logic        in_ws,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ip,
  output logic [31:0] out_wt,
  output logic [15:0] out_sx,
  output logic [15:0] out_sy,
  output logic        out_mode1,
  output logic        out_mode2,
  output logic        out_last
);

  typedef enum logic [1:0] {PREC_8B, PREC_4B, PREC_2B} prec_e;

  function automatic prec_e map_prec(input logic [1:0] c);
    case (c)
      2'd1:    return PREC_4B;
      2'd2:    return PREC_2B;
      default: return PREC_8B;
    endcase
  endfunction

  // Slot byte for one nibble: ip repeats {d1,d0}, wt duplicates each digit.
  function automatic logic [7:0] slot_ip(input logic [3:0] n);
    return {n[3:2], n[1:0], n[3:2], n[1:0]};
  endfunction

  function automatic logic [7:0] slot_wt(input logic [3:0] n);
    return {n[3:2], n[3:2], n[1:0], n[1:0]};
  endfunction

  logic [31:0] w_ip, w_wt;
  logic [15:0] w_sx, w_sy;
  prec_e       w_prec;
  logic [4:0]  w_cnt;
  logic        w_full, w_last;
  logic [7:0]  idle_cnt;

  logic        accept, out_free, idle, tmo;
  logic        close_now, load_buf, load_direct, hold;
  prec_e       eff_prec;
  logic [4:0]  n_pairs, cnt_nxt;
  logic [31:0] p_ip, p_wt, m_ip, m_wt;
  logic [15:0] p_sx, p_sy, m_sx, m_sy;
  logic        m_last;

  assign in_ready = !w_full;

  always_comb begin
    accept   = in_valid && in_ready;
    out_free = !out_valid || out_ready;
    eff_prec = (w_cnt == '0) ? map_prec(cfg_prec) : w_prec;
    cnt_nxt  = w_cnt + 5'd1;

    case (eff_prec)
      PREC_4B: n_pairs = 5'd4;
      PREC_2B: n_pairs = 5'd16;
      default: n_pairs = 5'd1;
    endcase

    p_ip = '0;
    p_wt = '0;
    p_sx = '0;
    p_sy = '0;
    if (accept) begin
      case (eff_prec)
        PREC_4B: begin
          p_ip = 32'(slot_ip(in_x[3:0])) << {w_cnt[1:0], 3'b000};
          p_wt = 32'(slot_wt(in_w[3:0])) << {w_cnt[1:0], 3'b000};
          p_sx = (in_xs ? 16'h000A : 16'h0000) << {w_cnt[1:0], 2'b00};
          p_sy = (in_ws ? 16'h000C : 16'h0000) << {w_cnt[1:0], 2'b00};
        end
        PREC_2B: begin
          p_ip = 32'(in_x[1:0]) << {w_cnt[3:0], 1'b0};
          p_wt = 32'(in_w[1:0]) << {w_cnt[3:0], 1'b0};
          p_sx = 16'(in_xs) << w_cnt[3:0];
          p_sy = 16'(in_ws) << w_cnt[3:0];
        end
        default: begin
          // Slots in order: (x_lo,w_lo), (x_hi,w_lo), (x_lo,w_hi), (x_hi,w_hi).
          p_ip = {slot_ip(in_x[7:4]), slot_ip(in_x[3:0]),
                  slot_ip(in_x[7:4]), slot_ip(in_x[3:0])};
          p_wt = {slot_wt(in_w[7:4]), slot_wt(in_w[7:4]),
                  slot_wt(in_w[3:0]), slot_wt(in_w[3:0])};
          p_sx = in_xs ? 16'hA0A0 : 16'h0000;
          p_sy = in_ws ? 16'hCC00 : 16'h0000;
        end
      endcase
    end

    m_ip   = w_ip | p_ip;
    m_wt   = w_wt | p_wt;
    m_sx   = w_sx | p_sx;
    m_sy   = w_sy | p_sy;
    m_last = accept && in_last;

    idle = (w_cnt != '0) && !w_full && !accept;
    tmo  = (FLUSH_TIMEOUT != 0) && idle &&
           ((32'(idle_cnt) + 32'd1) >= FLUSH_TIMEOUT);

    close_now   = (accept && (in_last || cnt_nxt == n_pairs)) || tmo;
    load_buf    = w_full && out_free;
    load_direct = close_now && out_free;
    hold        = close_now && !out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ip   <= '0;
      w_wt   <= '0;
      w_sx   <= '0;
      w_sy   <= '0;
      w_prec <= PREC_8B;
      w_cnt  <= '0;
      w_full <= 1'b0;
      w_last <= 1'b0;
    end else if (load_buf || load_direct) begin
      w_ip   <= '0;
      w_wt   <= '0;
      w_sx   <= '0;
      w_sy   <= '0;
      w_cnt  <= '0;
      w_full <= 1'b0;
      w_last <= 1'b0;
    end else if (hold || accept) begin
      w_ip   <= m_ip;
      w_wt   <= m_wt;
      w_sx   <= m_sx;
      w_sy   <= m_sy;
      w_prec <= eff_prec;
      w_cnt  <= accept ? cnt_nxt : w_cnt;
      w_full <= hold;
      w_last <= m_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!idle || tmo) begin
      idle_cnt <= '0;
    end else if (idle_cnt != '1) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ip    <= '0;
      out_wt    <= '0;
      out_sx    <= '0;
      out_sy    <= '0;
      out_mode1 <= 1'b0;
      out_mode2 <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_buf) begin
      out_valid <= 1'b1;
      out_ip    <= w_ip;
      out_wt    <= w_wt;
      out_sx    <= w_sx;
      out_sy    <= w_sy;
      out_mode1 <= (w_prec != PREC_2B);
      out_mode2 <= (w_prec == PREC_8B);
      out_last  <= w_last;
    end else if (load_direct) begin
      out_valid <= 1'b1;
      out_ip    <= m_ip;
      out_wt    <= m_wt;
      out_sx    <= m_sx;
      out_sy    <= m_sy;
      out_mode1 <= (eff_prec != PREC_2B);
      out_mode2 <= (eff_prec == PREC_8B);
      out_last  <= m_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
